// File: rtl/gf163_mul_word_io.sv
// GF(2^163) multiplier with a 32-bit word-serial stream interface.
// karatsuba_163x163: combinational product c = a*b mod x^163+x^7+x^6+x^3+1,
// one Karatsuba split (82/81-bit halves) followed by polynomial reduction.
// gf163_mul_word_io: loads a then b as six LSW-first words, lets the product
// settle for MUL_WAIT cycles, captures it, and streams it back as six words.

module karatsuba_163x163 (
    input  logic [162:0] a,
    input  logic [162:0] b,
    output logic [162:0] c
);
    // Field polynomial x^163 + x^7 + x^6 + x^3 + 1, widened to the raw product size.
    localparam logic [324:0] FPOLY = {161'b0, 1'b1, 155'b0, 8'hC9};

    function automatic logic [162:0] clmul82(input logic [81:0] x, input logic [81:0] y);
        logic [162:0] r;
        r = '0;
        for (int i = 0; i < 82; i++) begin
            if (y[i]) r = r ^ ({81'b0, x} << i);
        end
        return r;
    endfunction

    function automatic logic [162:0] reduce(input logic [324:0] p);
        logic [324:0] r;
        r = p;
        for (int i = 324; i >= 163; i--) begin
            if (r[i]) r = r ^ (FPOLY << (i - 163));
        end
        return r[162:0];
    endfunction

    logic [81:0]  a_lo, a_hi, b_lo, b_hi;
    logic [162:0] p_lo, p_hi, p_mid;
    logic [324:0] prod;

    assign a_lo  = a[81:0];
    assign a_hi  = {1'b0, a[162:82]};
    assign b_lo  = b[81:0];
    assign b_hi  = {1'b0, b[162:82]};
    assign p_lo  = clmul82(a_lo, b_lo);
    assign p_hi  = clmul82(a_hi, b_hi);
    assign p_mid = clmul82(a_lo ^ a_hi, b_lo ^ b_hi);
    assign prod  = {162'b0, p_lo}
                 ^ ({162'b0, p_mid ^ p_lo ^ p_hi} << 82)
                 ^ ({162'b0, p_hi} << 164);
    assign c     = reduce(prod);
endmodule

module gf163_mul_word_io #(
    parameter int MUL_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [1:0] {LOAD_A, LOAD_B, MUL, UNLOAD} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MUL_WAIT - 1);

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   wait_q, wait_d;
    logic [162:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [162:0] c;

    // Word 5 only contributes bits [162:160]; its upper 29 bits are dropped.
    function automatic logic [162:0] put_word(input logic [162:0] v, input logic [2:0] idx,
                                              input logic [31:0] w);
        logic [162:0] r;
        r = v;
        case (idx)
            3'd0:    r[31:0]    = w;
            3'd1:    r[63:32]   = w;
            3'd2:    r[95:64]   = w;
            3'd3:    r[127:96]  = w;
            3'd4:    r[159:128] = w;
            default: r[162:160] = w[2:0];
        endcase
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [162:0] v, input logic [2:0] idx);
        logic [31:0] r;
        case (idx)
            3'd0:    r = v[31:0];
            3'd1:    r = v[63:32];
            3'd2:    r = v[95:64];
            3'd3:    r = v[127:96];
            3'd4:    r = v[159:128];
            default: r = {29'b0, v[162:160]};
        endcase
        return r;
    endfunction

    // a/b are held in registers so the multiplier sees stable inputs during MUL.
    karatsuba_163x163 u_mul (
        .a(a_q),
        .b(b_q),
        .c(c)
    );

    // State, counters and operand/result registers; everything clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Next-state: word loading, settle countdown, and result unloading.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            LOAD_A: begin
                if (in_valid) begin
                    a_d = put_word(a_q, cnt_q, in_data);
                    if (cnt_q == 3'd5) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    b_d = put_word(b_q, cnt_q, in_data);
                    if (cnt_q == 3'd5) begin
                        cnt_d   = '0;
                        wait_d  = '0;
                        state_d = MUL;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MUL: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == WAIT_LAST) begin
                    res_d   = c;
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end
            end
            default: begin
                if (out_ready) begin
                    if (cnt_q == 3'd5) begin
                        cnt_d   = '0;
                        state_d = LOAD_A;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
        endcase
    end

    // Outputs decode registered state only; all are forced low while in reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        if (rst_n) begin
            case (state_q)
                LOAD_A, LOAD_B: in_ready = 1'b1;
                MUL:            busy     = 1'b1;
                default: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                    out_last  = (cnt_q == 3'd5);
                    out_data  = get_word(res_q, cnt_q);
                end
            endcase
        end
    end
endmodule

// File: doc/gf163_mul_word_io.md
Name: gf163_mul_word_io

Overview:
- Word-serial front/back end for the combinational GF(2^163) Karatsuba multiplier `karatsuba_163x163`, with ports `(a[162:0], b[162:0], c[162:0])`.
- Accepts operands a and b as 32-bit words over a valid/ready stream and presents them to one internal multiplier instance.
- Captures the 163-bit product after a programmable settle delay, then streams it out as 32-bit words.
- Sits between the bus-side operand source and the multiplier; it is the multiplier's only driver and consumer.

Parameters:
- MUL_WAIT, 2: cycles between holding both operands stable and capturing c (legal range 1..15; covers the multicycle path through the multiplier).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_data carries a valid word
- in_ready  output  1  block accepts a word this cycle
- in_data  input  32  operand word
- out_valid  output  1  out_data carries a result word
- out_ready  input  1  consumer accepts the word this cycle
- out_data  output  32  result word
- out_last  output  1  marks the final (6th) result word
- busy  output  1  high in MUL and UNLOAD states

Behaviour:
- Word packing: 163 bits are split into 6 words, least-significant word (LSW) first. Word i holds bits [32i+31:32i].
- Word 5 carries bits [162:160] in in_data[2:0]. in_data[31:3] of word 5 is ignored (never stored).
- Input order: a word0..5, then b word0..5. That is 12 input handshakes.
- Handshakes occur only on rising edges where valid && ready.
- States:
  - LOAD_A: in_ready=1. Each handshake stores a word and increments a 3-bit word counter. On the 6th handshake: counter<=0, go to LOAD_B.
  - LOAD_B: same as LOAD_A but stores into b. On the 6th handshake: go to MUL, wait counter<=0.
  - MUL: in_ready=0. The a/b registers drive the multiplier and are held stable. The wait counter increments each cycle. When wait==MUL_WAIT-1: result register<=c, word counter<=0, go to UNLOAD.
  - UNLOAD: out_valid=1. out_data = result word[counter], with bits [31:3] of word 5 forced to 0. out_last=1 when counter==5. Each handshake increments the counter. The handshake with out_last=1 returns the block to LOAD_A.
- Latency: if the 12th input handshake is at edge k, out_valid rises after edge k+MUL_WAIT. The first out_data word is valid in that same cycle.
- Stall rules:
  - in_valid gaps leave the counter and stored words unchanged.
  - While out_valid=1 && out_ready=0: out_data and out_last hold stable and out_valid stays high.
- in_valid outside LOAD_A/LOAD_B has no effect (in_ready=0).
- in_ready is 0 throughout UNLOAD, including the cycle of the last output handshake. The next load can begin on the following cycle.
- in_ready, out_valid, out_last and busy are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Reset (rst_n=0 at an edge): state<=LOAD_A, counters<=0, a/b/result registers<=0.
  - While rst_n=0: in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0.
  - After release: in_ready=1 from the first cycle.
- Reset mid-operation (any state) discards partial operands and any pending result. No output word is emitted afterwards for the aborted transaction.
- out_ready asserted outside UNLOAD has no effect.

Test Plan:
- Identity: a=1 (words 1,0,0,0,0,0), b=0x5_89ABCDEF_01234567_DEADBEEF_CAFEF00D_12345678 → out words 0x12345678, 0xCAFEF00D, 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0x5 with out_last only on the 6th. out_valid first high MUL_WAIT cycles after the 12th input edge.
- Simple product: a=x (0x2), b=x (0x2) → result 0x4 (words 4,0,0,0,0,0). Repeat back-to-back with a=0x3, b=0x3 → 0x5. No in_ready during UNLOAD, and the second load starts the cycle after the first out_last handshake.
- Ignored upper bits: a words 0,0,0,0,0,0xFFFFFFF8 (a=0), b=all 163 ones → all six output words 0. Also send b word5=0xFFFFFFFF and confirm out word5 bits [31:3]=0 in the identity case.
- Backpressure and bubbles: drop in_valid randomly during loading. Hold out_ready=0 for 5 cycles on output word 2 → out_data, out_last and out_valid stable throughout; word order unchanged; in_ready=0 throughout.
- Reset mid-load and mid-unload:
  - rst_n=0 for 1 cycle after 7 input words → next 12 words (a=2, b=2) yield 0x4.
  - rst_n=0 during UNLOAD word 3 → out_valid=0 from the next cycle, in_ready=1 after release, and no stale words are emitted.
- MUL_WAIT=1 and MUL_WAIT=15 builds: identity test passes, with out_valid rising exactly 1 and 15 cycles after the 12th input edge respectively.
